// File: rtl/player_motion_ctrl_pkg.sv
// Shared constants, state type and helpers for the player movement engine.
// Optional feature macro: PLAYER_CTRL_AI_EN (adds the ball-following AI inputs).
package player_motion_ctrl_pkg;

    localparam logic [11:0]        X_MIN    = 12'd592;
    localparam logic [11:0]        X_MAX    = 12'd944;
    localparam logic [11:0]        X_START  = 12'd800;
    localparam logic [11:0]        Y_GROUND = 12'd680;
    localparam logic signed [12:0] H_SPEED  = 13'sd4;
    localparam logic signed [7:0]  JUMP_V   = 8'sd18;
    localparam logic signed [7:0]  GRAVITY  = 8'sd1;

    typedef enum logic {
        GROUND = 1'b0,
        AIR    = 1'b1
    } state_t;

    // Sign-extend the 8-bit velocity to the 13-bit position arithmetic width.
    function automatic logic signed [12:0] widen_vy(input logic signed [7:0] v);
        return {{5{v[7]}}, v};
    endfunction

    // Horizontal step done in 13-bit signed so a step below zero cannot wrap, then clamped to the court.
    function automatic logic [11:0] step_x(input logic [11:0] x, input logic signed [12:0] d);
        logic signed [12:0] s;
        s = $signed({1'b0, x}) + d;
        if (s < $signed({1'b0, X_MIN})) return X_MIN;
        if (s > $signed({1'b0, X_MAX})) return X_MAX;
        return s[11:0];
    endfunction

endpackage

// File: rtl/player_motion_ctrl_if.sv
// Control/position bundle between the game logic (master) and the movement engine (slave).
// With PLAYER_CTRL_AI_EN defined the bundle also carries ai_mode and ball_xpos.
interface player_motion_ctrl_if;
    logic        vblnk_in;
    logic        btn_left;
    logic        btn_right;
    logic        btn_jump;
    logic        freeze;
    logic        respawn;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        in_air;
    logic        pos_valid;
`ifdef PLAYER_CTRL_AI_EN
    logic        ai_mode;
    logic [11:0] ball_xpos;

    modport master (
        output vblnk_in, btn_left, btn_right, btn_jump, freeze, respawn, ai_mode, ball_xpos,
        input  xpos, ypos, in_air, pos_valid
    );
    modport slave (
        input  vblnk_in, btn_left, btn_right, btn_jump, freeze, respawn, ai_mode, ball_xpos,
        output xpos, ypos, in_air, pos_valid
    );
`else
    modport master (
        output vblnk_in, btn_left, btn_right, btn_jump, freeze, respawn,
        input  xpos, ypos, in_air, pos_valid
    );
    modport slave (
        input  vblnk_in, btn_left, btn_right, btn_jump, freeze, respawn,
        output xpos, ypos, in_air, pos_valid
    );
`endif
endinterface

// File: rtl/player_motion_ctrl_frame_tick_gen.sv
// Frame tick generator: one-cycle pulse one pclk after each rising edge of vblnk.
module frame_tick_gen (
    input  logic pclk,
    input  logic rst,
    input  logic vblnk_in,
    output logic tick
);

    logic vblnk_d;

    // Delay vblnk by one cycle and register the rising-edge detect as the tick.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            vblnk_d <= 1'b0;
            tick    <= 1'b0;
        end else begin
            vblnk_d <= vblnk_in;
            tick    <= vblnk_in & ~vblnk_d;
        end
    end

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-player movement engine: frame-rate horizontal motion, jump ballistics, court clamping.
// Optional feature macro: PLAYER_CTRL_AI_EN (ball-following steering and auto-jump).
module player_motion_ctrl
    import player_motion_ctrl_pkg::*;
(
    input  logic                 pclk,
    input  logic                 rst,
    player_motion_ctrl_if.slave  bus
);

    logic               tick;
    state_t             state, state_nxt;
    logic [11:0]        xpos, xpos_nxt;
    logic [11:0]        ypos, ypos_nxt;
    logic signed [7:0]  vy, vy_nxt;
    logic               jump_prev, jump_prev_nxt;
    logic               pos_valid, pos_valid_nxt;
    logic               move_left, move_right, jump_req;
    logic signed [12:0] y_sum;

    frame_tick_gen u_tick (
        .pclk     (pclk),
        .rst      (rst),
        .vblnk_in (bus.vblnk_in),
        .tick     (tick)
    );

`ifdef PLAYER_CTRL_AI_EN
    logic signed [12:0] ball_dx;
    assign ball_dx = $signed({1'b0, bus.ball_xpos}) - $signed({1'b0, xpos});

    // Select movement requests: AI steers toward the ball with an 8 px deadband, else buttons.
    always_comb begin
        move_left  = bus.btn_left;
        move_right = bus.btn_right;
        jump_req   = bus.btn_jump;
        if (bus.ai_mode) begin
            move_left  = (ball_dx < -13'sd8);
            move_right = (ball_dx > 13'sd8);
            jump_req   = (ball_dx > -13'sd32) && (ball_dx < 13'sd32);
        end
    end
`else
    assign move_left  = bus.btn_left;
    assign move_right = bus.btn_right;
    assign jump_req   = bus.btn_jump;
`endif

    // State and position registers.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state     <= GROUND;
            xpos      <= X_START;
            ypos      <= Y_GROUND;
            vy        <= 8'sd0;
            jump_prev <= 1'b0;
            pos_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            xpos      <= xpos_nxt;
            ypos      <= ypos_nxt;
            vy        <= vy_nxt;
            jump_prev <= jump_prev_nxt;
            pos_valid <= pos_valid_nxt;
        end
    end

    // Next-state logic: respawn beats freeze and tick; motion only on unfrozen ticks.
    always_comb begin
        state_nxt     = state;
        xpos_nxt      = xpos;
        ypos_nxt      = ypos;
        vy_nxt        = vy;
        jump_prev_nxt = jump_prev;
        pos_valid_nxt = 1'b0;
        y_sum         = $signed({1'b0, ypos}) + widen_vy(vy);

        if (bus.respawn) begin
            state_nxt     = GROUND;
            xpos_nxt      = X_START;
            ypos_nxt      = Y_GROUND;
            vy_nxt        = 8'sd0;
            pos_valid_nxt = 1'b1;
        end else if (tick && !bus.freeze) begin
            pos_valid_nxt = 1'b1;
            jump_prev_nxt = jump_req;

            if (move_left && !move_right)
                xpos_nxt = step_x(xpos, -H_SPEED);
            else if (move_right && !move_left)
                xpos_nxt = step_x(xpos, H_SPEED);

            case (state)
                GROUND: begin
                    // Launch tick already applies the first step and one gravity increment.
                    if (jump_req && !jump_prev) begin
                        state_nxt = AIR;
                        ypos_nxt  = 12'($signed({1'b0, ypos}) - widen_vy(JUMP_V));
                        vy_nxt    = GRAVITY - JUMP_V;
                    end
                end
                AIR: begin
                    if (y_sum >= $signed({1'b0, Y_GROUND})) begin
                        state_nxt = GROUND;
                        ypos_nxt  = Y_GROUND;
                        vy_nxt    = 8'sd0;
                    end else begin
                        ypos_nxt  = y_sum[11:0];
                        vy_nxt    = vy + GRAVITY;
                    end
                end
            endcase
        end
    end

    assign bus.xpos      = xpos;
    assign bus.ypos      = ypos;
    assign bus.in_air    = (state == AIR);
    assign bus.pos_valid = pos_valid;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Self-checking bench for player_motion_ctrl with a frame-level behavioural reference model.
// Build with PLAYER_CTRL_AI_EN defined to also exercise the AI steering mode.
module tb_player_motion_ctrl;

    logic pclk = 1'b0;
    logic rst;

    player_motion_ctrl_if bus ();

    player_motion_ctrl dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 pclk = ~pclk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state, one update per frame.
    int mx;
    int my;
    int mt;
    bit mair;
    bit mjprev;

    // Height after t ticks of flight (closed-form ballistics from launch speed 18, gravity 1).
    function automatic int traj(input int t);
        return 680 - (18 * t - (t * (t - 1)) / 2);
    endfunction

    task automatic model_reset(input bit clear_jump);
        mx = 800; my = 680; mt = 0; mair = 1'b0;
        if (clear_jump) mjprev = 1'b0;
    endtask

    task automatic model_step(input bit l, input bit r, input bit j, input bit f);
        bit rise;
        if (f) return;
        rise   = j && !mjprev;
        mjprev = j;
        if (l && !r)      mx = (mx - 4 < 592) ? 592 : mx - 4;
        else if (r && !l) mx = (mx + 4 > 944) ? 944 : mx + 4;
        if (!mair) begin
            if (rise) begin
                mair = 1'b1; mt = 1; my = traj(1);
            end
        end else begin
            mt++;
            if (traj(mt) >= 680) begin
                my = 680; mair = 1'b0; mt = 0;
            end else begin
                my = traj(mt);
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        vectors++;
        if (bus.xpos !== 12'(mx)) begin
            miscompares++;
            $display("FAIL %s xpos: got %0d want %0d", tag, bus.xpos, mx);
        end
        vectors++;
        if (bus.ypos !== 12'(my)) begin
            miscompares++;
            $display("FAIL %s ypos: got %0d want %0d", tag, bus.ypos, my);
        end
        vectors++;
        if (bus.in_air !== mair) begin
            miscompares++;
            $display("FAIL %s in_air: got %0b want %0b", tag, bus.in_air, mair);
        end
    endtask

    // One video frame: drive inputs, pulse vblnk, count pos_valid pulses, compare with model.
    task automatic run_frame(input bit l, input bit r, input bit j, input bit f, input string tag);
        int pulses;
        bit el, er, ej;
        @(negedge pclk);
        bus.btn_left  = l;
        bus.btn_right = r;
        bus.btn_jump  = j;
        bus.freeze    = f;
        el = l; er = r; ej = j;
`ifdef PLAYER_CTRL_AI_EN
        if (bus.ai_mode) begin
            int dx;
            dx = int'(bus.ball_xpos) - mx;
            el = (dx < -8);
            er = (dx > 8);
            ej = (dx > -32) && (dx < 32);
        end
`endif
        model_step(el, er, ej, f);
        bus.vblnk_in = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge pclk);
            if (bus.pos_valid === 1'b1) pulses++;
        end
        bus.vblnk_in = 1'b0;
        repeat (4) begin
            @(negedge pclk);
            if (bus.pos_valid === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != (f ? 0 : 1)) begin
            miscompares++;
            $display("FAIL %s pos_valid pulses: got %0d want %0d", tag, pulses, (f ? 0 : 1));
        end
        check_outputs(tag);
    endtask

    task automatic test_reset();
        check_outputs("reset");
        vectors++;
        if (bus.pos_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset pos_valid: got %0b want 0", bus.pos_valid);
        end
        repeat (3) run_frame(1'b0, 1'b0, 1'b0, 1'b0, "idle");
    endtask

    task automatic test_right_saturate();
        repeat (50) run_frame(1'b0, 1'b1, 1'b0, 1'b0, "right");
        repeat (3)  run_frame(1'b1, 1'b1, 1'b0, 1'b0, "both");
        repeat (100) run_frame(1'b1, 1'b0, 1'b0, 1'b0, "left");
        repeat (20) run_frame(1'b0, 1'b1, 1'b0, 1'b0, "right2");
    endtask

    task automatic test_jump();
        int apex;
        apex = 4095;
        run_frame(1'b0, 1'b0, 1'b1, 1'b0, "jump_launch");
        if (bus.ypos < apex) apex = bus.ypos;
        repeat (39) begin
            run_frame(1'b0, 1'b0, 1'b0, 1'b0, "jump_flight");
            if (bus.ypos < apex) apex = bus.ypos;
        end
        vectors++;
        if (apex != 509) begin
            miscompares++;
            $display("FAIL jump apex: got %0d want 509", apex);
        end
        repeat (45) run_frame(1'b0, 1'b0, 1'b1, 1'b0, "jump_held");
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, "jump_release");
    endtask

    task automatic test_respawn_freeze();
        run_frame(1'b0, 1'b1, 1'b1, 1'b0, "rsp_launch");
        repeat (5) run_frame(1'b0, 1'b1, 1'b0, 1'b0, "rsp_air");
        repeat (2) run_frame(1'b1, 1'b0, 1'b0, 1'b1, "frozen");
        @(negedge pclk);
        bus.freeze  = 1'b1;
        bus.respawn = 1'b1;
        @(negedge pclk);
        bus.respawn = 1'b0;
        model_reset(1'b0);
        check_outputs("respawn");
        vectors++;
        if (bus.pos_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL respawn pos_valid: got %0b want 1", bus.pos_valid);
        end
        @(negedge pclk);
        vectors++;
        if (bus.pos_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL respawn pos_valid second cycle: got %0b want 0", bus.pos_valid);
        end
        bus.freeze = 1'b0;
        repeat (2) run_frame(1'b0, 1'b0, 1'b0, 1'b0, "after_respawn");
    endtask

    task automatic test_async_reset();
        run_frame(1'b1, 1'b0, 1'b1, 1'b0, "rst_launch");
        repeat (4) run_frame(1'b1, 1'b0, 1'b0, 1'b0, "rst_air");
        @(posedge pclk);
        #2;
        rst = 1'b0;
        #1;
        model_reset(1'b1);
        check_outputs("async_reset");
        vectors++;
        if (bus.pos_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset pos_valid: got %0b want 0", bus.pos_valid);
        end
        bus.btn_left = 1'b0;
        bus.btn_jump = 1'b0;
        @(negedge pclk);
        rst = 1'b1;
        repeat (2) run_frame(1'b0, 1'b0, 1'b0, 1'b0, "post_reset");
    endtask

    task automatic test_random();
        repeat (150) begin
            bit l, r, j, f;
            l = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 2) == 0);
            j = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 9) == 0);
            run_frame(l, r, j, f, "random");
        end
    endtask

`ifdef PLAYER_CTRL_AI_EN
    task automatic test_ai();
        @(negedge pclk);
        bus.respawn = 1'b1;
        @(negedge pclk);
        bus.respawn = 1'b0;
        model_reset(1'b0);
        check_outputs("ai_start");
        bus.ai_mode   = 1'b1;
        bus.ball_xpos = 12'd700;
        repeat (40) run_frame(1'b0, 1'b1, 1'b0, 1'b0, "ai_track");
        bus.ball_xpos = 12'(500 + $urandom_range(0, 500));
        repeat (40) run_frame(1'b1, 1'b0, 1'b1, 1'b0, "ai_random");
        bus.ai_mode = 1'b0;
    endtask
`endif

    initial begin
        rst           = 1'b0;
        bus.vblnk_in  = 1'b0;
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        bus.btn_jump  = 1'b0;
        bus.freeze    = 1'b0;
        bus.respawn   = 1'b0;
`ifdef PLAYER_CTRL_AI_EN
        bus.ai_mode   = 1'b0;
        bus.ball_xpos = 12'd0;
`endif
        model_reset(1'b1);
        repeat (3) @(negedge pclk);
        rst = 1'b1;
        @(negedge pclk);

        test_reset();
        test_right_saturate();
        test_jump();
        test_respawn_freeze();
        test_async_reset();
        test_random();
`ifdef PLAYER_CTRL_AI_EN
        test_ai();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
